// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - TX/RX byte FIFOs between CPU decode and the uart_simple strobe interface
module uart_fifo_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  localparam int TCW = $clog2(TX_DEPTH) + 1,
  localparam int RCW = $clog2(RX_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     wr_data,
  input  logic           wr_en,
  output logic           tx_full,
  output logic [TCW-1:0] tx_count,
  output logic [7:0]     rd_data,
  input  logic           rd_en,
  output logic           rx_empty,
  output logic [RCW-1:0] rx_count,
  output logic           rx_overrun,
  input  logic           ovr_clr,
  output logic [7:0]     u_tx_data,
  output logic           u_tx_wr,
  input  logic           u_tx_busy,
  input  logic [7:0]     u_rx_data,
  input  logic           u_rx_valid,
  output logic           u_rx_ack
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_WAIT} tx_state_e;
  typedef enum logic {R_IDLE, R_ACK} rx_state_e;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_rptr_q;
  logic [RAW-1:0] rx_wptr_q, rx_rptr_q;
  logic [TCW-1:0] tx_count_q, tx_count_d;
  logic [RCW-1:0] rx_count_q, rx_count_d;
  tx_state_e      tx_state_q;
  rx_state_e      rx_state_q;
  logic [7:0]     u_tx_data_q;
  logic           u_tx_wr_q, u_rx_ack_q, rx_overrun_q;

  logic tx_push, tx_pop, rx_full, rx_pop, rx_capture, rx_push, rx_drop;

  assign tx_full  = (tx_count_q == TCW'(TX_DEPTH));
  assign tx_push  = wr_en && !tx_full;
  assign tx_pop   = (tx_state_q == T_IDLE) && (tx_count_q != '0) && !u_tx_busy;

  assign rx_empty   = (rx_count_q == '0);
  assign rx_full    = (rx_count_q == RCW'(RX_DEPTH));
  assign rx_pop     = rd_en && !rx_empty;
  assign rx_capture = (rx_state_q == R_IDLE) && u_rx_valid;
  // A same-cycle read frees a slot, so a full FIFO being read still takes the byte.
  assign rx_push    = rx_capture && (!rx_full || rx_pop);
  assign rx_drop    = rx_capture && !rx_push;

  always_comb begin
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TCW'(1);
      2'b01:   tx_count_d = tx_count_q - TCW'(1);
      default: tx_count_d = tx_count_q;
    endcase
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RCW'(1);
      2'b01:   rx_count_d = rx_count_q - RCW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= wr_data;
    if (rx_push) rx_mem[rx_wptr_q] <= u_rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      tx_state_q   <= T_IDLE;
      rx_state_q   <= R_IDLE;
      u_tx_data_q  <= '0;
      u_tx_wr_q    <= 1'b0;
      u_rx_ack_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + TAW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TAW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + RAW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + RAW'(1);

      // T_LAUNCH absorbs the one cycle before the core raises tx_busy.
      case (tx_state_q)
        T_IDLE: if (tx_pop) begin
          u_tx_data_q <= tx_mem[tx_rptr_q];
          u_tx_wr_q   <= 1'b1;
          tx_state_q  <= T_LAUNCH;
        end
        T_LAUNCH: begin
          u_tx_wr_q  <= 1'b0;
          tx_state_q <= T_WAIT;
        end
        T_WAIT:  if (!u_tx_busy) tx_state_q <= T_IDLE;
        default: tx_state_q <= T_IDLE;
      endcase

      case (rx_state_q)
        R_IDLE: if (u_rx_valid) begin
          u_rx_ack_q <= 1'b1;
          rx_state_q <= R_ACK;
        end
        R_ACK: begin
          u_rx_ack_q <= 1'b0;
          rx_state_q <= R_IDLE;
        end
        default: rx_state_q <= R_IDLE;
      endcase

      if (rx_drop)      rx_overrun_q <= 1'b1;
      else if (ovr_clr) rx_overrun_q <= 1'b0;
    end
  end

  assign tx_count   = tx_count_q;
  assign rx_count   = rx_count_q;
  assign rx_overrun = rx_overrun_q;
  assign u_tx_data  = u_tx_data_q;
  assign u_tx_wr    = u_tx_wr_q;
  assign u_rx_ack   = u_rx_ack_q;
  assign rd_data    = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - directed self-checking bench for uart_fifo_bridge
module tb_uart_fifo_bridge;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       tx_full;
  logic [4:0] tx_count;
  logic [7:0] rd_data;
  logic       rd_en;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       rx_overrun;
  logic       ovr_clr;
  logic [7:0] u_tx_data;
  logic       u_tx_wr;
  logic       u_tx_busy;
  logic [7:0] u_rx_data;
  logic       u_rx_valid;
  logic       u_rx_ack;

  int n_chk  = 0;
  int n_fail = 0;

  uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_data(wr_data), .wr_en(wr_en), .tx_full(tx_full), .tx_count(tx_count),
    .rd_data(rd_data), .rd_en(rd_en), .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
    .u_tx_data(u_tx_data), .u_tx_wr(u_tx_wr), .u_tx_busy(u_tx_busy),
    .u_rx_data(u_rx_data), .u_rx_valid(u_rx_valid), .u_rx_ack(u_rx_ack)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] d);
    u_rx_valid = 1'b1;
    u_rx_data  = d;
    step();
    chk("rx_ack_pulse", u_rx_ack, 1'b1);
    step();
    u_rx_valid = 1'b0;
    chk("rx_ack_low", u_rx_ack, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_full"}, tx_full, 1'b0);
    chk({tag, "_tx_count"}, tx_count, 5'd0);
    chk({tag, "_rx_empty"}, rx_empty, 1'b1);
    chk({tag, "_rx_count"}, rx_count, 5'd0);
    chk({tag, "_rx_overrun"}, rx_overrun, 1'b0);
    chk({tag, "_u_tx_wr"}, u_tx_wr, 1'b0);
    chk({tag, "_u_tx_data"}, u_tx_data, 8'h00);
    chk({tag, "_u_rx_ack"}, u_rx_ack, 1'b0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
  endtask

  initial begin
    int wait_cnt;
    reset_n = 1'b0; wr_data = 8'h00; wr_en = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    u_tx_busy = 1'b0; u_rx_data = 8'h00; u_rx_valid = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    // 1: single byte, two cycles from push to launch, exactly one pulse
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    chk("t1_count_after_push", tx_count, 5'd1);
    chk("t1_no_wr_yet", u_tx_wr, 1'b0);
    step();
    chk("t1_wr_pulse", u_tx_wr, 1'b1);
    chk("t1_tx_data", u_tx_data, 8'h41);
    chk("t1_count_after_pop", tx_count, 5'd0);
    u_tx_busy = 1'b1;
    step();
    chk("t1_wr_drop", u_tx_wr, 1'b0);
    step(); step();
    u_tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_single_pulse", u_tx_wr, 1'b0);
    end

    // 2: fill while the UART is busy, overflow push ignored, in-order drain
    u_tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      step();
    end
    chk("t2_full", tx_full, 1'b1);
    chk("t2_count16", tx_count, 5'd16);
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("t2_17th_ignored", tx_count, 5'd16);
    chk("t2_no_launch_while_busy", u_tx_wr, 1'b0);
    for (int i = 0; i < 16; i++) begin
      u_tx_busy = 1'b0;
      wait_cnt = 0;
      do begin
        step();
        wait_cnt++;
      end while (!u_tx_wr && wait_cnt < 4);
      chk("t2_wr_seen", u_tx_wr, 1'b1);
      chk("t2_wr_latency", 16'(wait_cnt), (i == 0) ? 16'd1 : 16'd2);
      chk("t2_drain_byte", u_tx_data, 8'h30 + 8'(i));
      u_tx_busy = 1'b1;
      step(); step();
    end
    u_tx_busy = 1'b0;
    chk("t2_empty", tx_count, 5'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_no_extra_byte", u_tx_wr, 1'b0);
    end

    // 3: single received byte then read
    rx_byte(8'h55);
    chk("t3_rx_count", rx_count, 5'd1);
    chk("t3_rd_data", rd_data, 8'h55);
    chk("t3_not_empty", rx_empty, 1'b0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t3_empty", rx_empty, 1'b1);
    chk("t3_rd_data_zero", rd_data, 8'h00);

    // 4: overflow drops the 17th byte; clear; set beats clear
    for (int i = 0; i < 16; i++) rx_byte(8'hA0 + 8'(i));
    chk("t4_count16", rx_count, 5'd16);
    chk("t4_no_overrun_yet", rx_overrun, 1'b0);
    rx_byte(8'hEE);
    chk("t4_overrun", rx_overrun, 1'b1);
    chk("t4_count_held", rx_count, 5'd16);
    chk("t4_head", rd_data, 8'hA0);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t4_cleared", rx_overrun, 1'b0);
    ovr_clr = 1'b1; u_rx_valid = 1'b1; u_rx_data = 8'hEF;
    step();
    ovr_clr = 1'b0;
    chk("t4_set_wins", rx_overrun, 1'b1);
    step();
    u_rx_valid = 1'b0;
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t4_cleared_again", rx_overrun, 1'b0);

    // 5: full FIFO with same-cycle read accepts the byte
    u_rx_valid = 1'b1; u_rx_data = 8'h77; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_ack", u_rx_ack, 1'b1);
    chk("t5_count16", rx_count, 5'd16);
    chk("t5_no_overrun", rx_overrun, 1'b0);
    chk("t5_head", rd_data, 8'hA1);
    step();
    u_rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t5_order", rd_data, (i < 15) ? 8'hA1 + 8'(i) : 8'h77);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    chk("t5_drained", rx_empty, 1'b1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_no_underflow", rx_count, 5'd0);

    // 6: asynchronous reset with TX in T_WAIT and RX holding data
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_data = 8'h11;
    step();
    wr_en = 1'b0;
    chk("t6_launch", u_tx_wr, 1'b1);
    chk("t6_count_pushpop", tx_count, 5'd1);
    u_tx_busy = 1'b1;
    step();
    u_rx_valid = 1'b1; u_rx_data = 8'h66;
    step();
    chk("t6_rx_held", rx_count, 5'd1);
    chk("t6_ack_high", u_rx_ack, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    u_rx_valid = 1'b0; u_tx_busy = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_idle_after_reset", u_tx_wr, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
